// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I MEM-stage load/store unit driving a single-port word RAM.
// Sub-word stores use read-modify-write; responses are one-cycle pulses with held data.
module load_store_unit #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_f3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAP, S_WRITE, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_bad_f3;
   logic        w_misalign;
   logic        w_range;
   logic        w_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merge;

   assign w_accept = req_valid && (r_state == S_IDLE);

   always_comb begin
      w_bad_f3   = req_we ? (req_f3 > 3'b010) : ((req_f3 == 3'b011) || (req_f3[2:1] == 2'b11));
      w_misalign = ((req_f3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      w_range    = {2'b00, req_addr[31:2]} >= DEPTH;
      w_err      = w_bad_f3 || w_misalign || w_range;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_err)                            w_next = S_RESP;
               else if (req_we && req_f3 == 3'b010)  w_next = S_WRITE;
               else                                  w_next = S_READ;
            end
         end
         S_READ:  w_next = S_CAP;
         S_CAP:   w_next = r_we ? S_WRITE : S_RESP;
         S_WRITE: w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (r_state == S_IDLE);
      resp_valid = (r_state == S_RESP);
      mem_we     = (r_state == S_WRITE);
   end

   // Little-endian lane select on the word returned in CAP.
   always_comb begin
      w_byte = mem_rdata[{r_off, 3'b000} +: 8];
      w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
      case (r_f3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'h0, w_byte};
         3'b101:  w_load_data = {16'h0, w_half};
         default: w_load_data = mem_rdata;
      endcase
      w_merge = mem_rdata;
      if (r_f3[1:0] == 2'b00) w_merge[{r_off, 3'b000} +: 8]     = r_mem_wdata[7:0];
      else                    w_merge[{r_off[1], 4'b0000} +: 16] = r_mem_wdata[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_f3         <= 3'b000;
         r_off        <= 2'b00;
         r_mem_addr   <= 32'h0;
         r_mem_wdata  <= 32'h0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept && !w_err) begin
            r_we        <= req_we;
            r_f3        <= req_f3;
            r_off       <= req_addr[1:0];
            r_mem_addr  <= {req_addr[31:2], 2'b00};
            r_mem_wdata <= req_wdata;
         end
         if (r_state == S_CAP && r_we) r_mem_wdata <= w_merge;
         // Response registers change only on entry to RESP so they hold between responses.
         if (w_next == S_RESP && r_state != S_RESP) begin
            r_resp_err   <= (r_state == S_IDLE);
            r_resp_rdata <= (r_state == S_CAP) ? w_load_data : 32'h0;
         end
      end
   end

   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule
